// File: rtl/relu_pool_writer.sv
// Post-conv writer: optional ReLU, optional 2x2 stride-2 max pool, sequential memory writes.
// State table:  IDLE | no instruction yet, beats ignored
//               RUN  | consuming conv beats, writing results
//               DONE | all results written, beats ignored until next instruction
module relu_pool_writer #(
  parameter int DataWidth    = 32,
  parameter int MaxPictWidth = 9,
  parameter int MaxAddrWidth = 32,
  parameter int BufDepth     = 256
) (
  input  logic                    Clk0,
  input  logic                    Rst,
  input  logic [MaxPictWidth-1:0] out_size_in,
  input  logic [MaxAddrWidth-1:0] dst_addr_in,
  input  logic                    relu_en_in,
  input  logic                    pool_en_in,
  input  logic                    inst_tag_in,
  input  logic                    conv_en_in,
  input  logic [DataWidth-1:0]    conv_data_in,
  output logic                    mem_wr_en_out,
  output logic [MaxAddrWidth-1:0] mem_wr_addr_out,
  output logic [DataWidth-1:0]    mem_wr_data_out,
  output logic                    pool_done_out
);
  localparam int IdxWidth = $clog2(BufDepth);
  localparam int CntWidth = 2 * MaxPictWidth;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic                           tag_q;
  logic                           inst_changed;
  logic [MaxPictWidth-1:0]        size_q, col, row, half;
  logic [MaxAddrWidth-1:0]        next_addr;
  logic                           relu_q, pool_q;
  logic [CntWidth-1:0]            remain, size_ext, half_ext;
  logic signed [DataWidth-1:0]    hold, v, pair_max, quad_max, out_val, buf_rd;
  logic signed [DataWidth-1:0]    linebuf [BufDepth];
  logic [IdxWidth-1:0]            buf_idx;
  logic                           accept, emit, last;

  assign inst_changed = inst_tag_in ^ tag_q;
  assign buf_idx      = IdxWidth'(col >> 1);
  assign half         = out_size_in >> 1;
  assign size_ext     = CntWidth'(out_size_in);
  assign half_ext     = CntWidth'(half);
  assign buf_rd       = linebuf[buf_idx];

  always_comb begin
    state_nxt = state;
    v         = $signed(conv_data_in);
    if (relu_q && ($signed(conv_data_in) < 0)) v = '0;
    pair_max  = (hold > v) ? hold : v;
    quad_max  = (buf_rd > pair_max) ? buf_rd : pair_max;
    out_val   = pool_q ? quad_max : v;
    accept    = (state == RUN) && conv_en_in && !inst_changed;
    // in pool mode only the odd-row/odd-column beat closes a 2x2 window
    emit      = accept && (!pool_q || (row[0] && col[0]));
    last      = emit && (remain == CntWidth'(1));
    if (inst_changed)  state_nxt = RUN;
    else if (last)     state_nxt = DONE;
  end

  always_ff @(posedge Clk0) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge Clk0) begin
    if (Rst) begin
      tag_q           <= 1'b0;
      size_q          <= '0;
      relu_q          <= 1'b0;
      pool_q          <= 1'b0;
      next_addr       <= '0;
      col             <= '0;
      row             <= '0;
      remain          <= '0;
      hold            <= '0;
      mem_wr_en_out   <= 1'b0;
      mem_wr_addr_out <= '0;
      mem_wr_data_out <= '0;
      pool_done_out   <= 1'b0;
    end else begin
      tag_q         <= inst_tag_in;
      mem_wr_en_out <= emit;
      if (inst_changed) begin
        size_q        <= out_size_in;
        relu_q        <= relu_en_in;
        pool_q        <= pool_en_in;
        next_addr     <= dst_addr_in;
        col           <= '0;
        row           <= '0;
        remain        <= pool_en_in ? half_ext * half_ext : size_ext * size_ext;
        pool_done_out <= 1'b0;
      end else if (accept) begin
        if (col == size_q - MaxPictWidth'(1)) begin
          col <= '0;
          row <= row + MaxPictWidth'(1);
        end else begin
          col <= col + MaxPictWidth'(1);
        end
        if (!col[0]) hold <= v;
        if (emit) begin
          mem_wr_addr_out <= next_addr;
          mem_wr_data_out <= out_val;
          next_addr       <= next_addr + MaxAddrWidth'(1);
          remain          <= remain - CntWidth'(1);
          if (last) pool_done_out <= 1'b1;
        end
      end
    end
  end

  // even rows park their horizontal pair maxima for the odd row below
  always_ff @(posedge Clk0) begin
    if (accept && pool_q && !row[0] && col[0]) linebuf[buf_idx] <= pair_max;
  end

endmodule

// File: tb/tb_relu_pool_writer.sv
// Bench for relu_pool_writer: directed vectors, abort, reset and randomized instructions.
module tb_relu_pool_writer;
  logic        Clk0 = 1'b0;
  logic        Rst;
  logic [8:0]  out_size_in;
  logic [31:0] dst_addr_in;
  logic        relu_en_in, pool_en_in, inst_tag_in, conv_en_in;
  logic [31:0] conv_data_in;
  logic        mem_wr_en_out;
  logic [31:0] mem_wr_addr_out;
  logic [31:0] mem_wr_data_out;
  logic        pool_done_out;

  relu_pool_writer dut (
    .Clk0(Clk0), .Rst(Rst), .out_size_in(out_size_in), .dst_addr_in(dst_addr_in),
    .relu_en_in(relu_en_in), .pool_en_in(pool_en_in), .inst_tag_in(inst_tag_in),
    .conv_en_in(conv_en_in), .conv_data_in(conv_data_in), .mem_wr_en_out(mem_wr_en_out),
    .mem_wr_addr_out(mem_wr_addr_out), .mem_wr_data_out(mem_wr_data_out),
    .pool_done_out(pool_done_out)
  );

  always #5 Clk0 = ~Clk0;

  int cyc = 0;
  always @(posedge Clk0) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit tag      = 1'b0;

  logic [31:0]        wr_addr[$], wr_data[$];
  int                 wr_cyc[$], beat_edge[$], exp_i[$];
  logic signed [31:0] stim[$], exp_d[$];
  int                 done_cyc = -1;
  logic               done_prev = 1'b0;

  always @(negedge Clk0) begin
    if (mem_wr_en_out === 1'b1) begin
      wr_addr.push_back(mem_wr_addr_out);
      wr_data.push_back(mem_wr_data_out);
      wr_cyc.push_back(cyc);
    end
    if (pool_done_out === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = pool_done_out;
  end

  // Starts a new instruction (junk beat on the toggle cycle must be ignored), then feeds stim.
  task automatic drive_inst(input int n, input logic [31:0] dst, input bit relu,
                            input bit pool, input bit gaps);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); beat_edge.delete();
    done_cyc     = -1;
    out_size_in  = 9'(n);
    dst_addr_in  = dst;
    relu_en_in   = relu;
    pool_en_in   = pool;
    tag          = ~tag;
    inst_tag_in  = tag;
    conv_en_in   = 1'b1;
    conv_data_in = $urandom;
    @(posedge Clk0); #1;
    foreach (stim[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          conv_en_in = 1'b0; conv_data_in = $urandom;
          @(posedge Clk0); #1;
        end
      end
      conv_en_in = 1'b1; conv_data_in = stim[i];
      @(posedge Clk0); #1;
      beat_edge.push_back(cyc);
    end
    conv_en_in = 1'b0;
    repeat (3) @(posedge Clk0);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk0);
    @(negedge Clk0);
    n_checks++; if (mem_wr_en_out !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", mem_wr_en_out); end
    n_checks++; if (mem_wr_addr_out !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_wr_addr_out); end
    n_checks++; if (mem_wr_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", mem_wr_data_out); end
    n_checks++; if (pool_done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", pool_done_out); end
    Rst = 1'b0;
    @(posedge Clk0); #1;
  endtask

  task automatic test_directed();
    string name;
    logic [31:0] dst;
    int n; bit relu, pool;
    for (int t = 0; t < 5; t++) begin
      stim.delete(); exp_d.delete(); exp_i.delete();
      case (t)
        0: begin
          name = "pool_n4"; n = 4; relu = 0; pool = 1; dst = 32'h100;
          for (int k = 0; k < 16; k++) stim.push_back(k);
          exp_d = '{5, 7, 13, 15}; exp_i = '{5, 7, 13, 15};
        end
        1: begin
          name = "pool_n5"; n = 5; relu = 0; pool = 1; dst = 32'h180;
          for (int k = 0; k < 25; k++) stim.push_back(k);
          exp_d = '{6, 8, 16, 18}; exp_i = '{6, 8, 16, 18};
        end
        2: begin
          name = "pass_n3"; n = 3; relu = 1; pool = 0; dst = 32'h20;
          stim  = '{-3, 2, -1, 0, 5, -7, 1, 1, -2};
          exp_d = '{0, 2, 0, 0, 5, 0, 1, 1, 0};
          exp_i = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        end
        3: begin
          name = "signed_n2"; n = 2; relu = 0; pool = 1; dst = 32'h10;
          stim = '{-5, -2, -9, -1}; exp_d = '{-1}; exp_i = '{3};
        end
        default: begin
          name = "signed_relu_n2"; n = 2; relu = 1; pool = 1; dst = 32'h11;
          stim = '{-5, -2, -9, -1}; exp_d = '{0}; exp_i = '{3};
        end
      endcase
      drive_inst(n, dst, relu, pool, 1'b0);
      n_checks++;
      if (wr_data.size() != exp_d.size()) begin
        n_fail++; $display("FAIL %s count got %0d want %0d", name, wr_data.size(), exp_d.size());
      end
      for (int k = 0; k < exp_d.size() && k < wr_data.size(); k++) begin
        n_checks++;
        if (wr_data[k] !== exp_d[k]) begin
          n_fail++; $display("FAIL %s data[%0d] got %0d want %0d", name, k, $signed(wr_data[k]), exp_d[k]);
        end
        n_checks++;
        if (wr_addr[k] !== 32'(dst + k)) begin
          n_fail++; $display("FAIL %s addr[%0d] got %h want %h", name, k, wr_addr[k], 32'(dst + k));
        end
        n_checks++;
        if (wr_cyc[k] != beat_edge[exp_i[k]]) begin
          n_fail++; $display("FAIL %s latency[%0d] got cycle %0d want %0d", name, k, wr_cyc[k], beat_edge[exp_i[k]]);
        end
      end
      n_checks++;
      if (done_cyc != beat_edge[exp_i[exp_i.size()-1]]) begin
        n_fail++; $display("FAIL %s done_rise got %0d want %0d", name, done_cyc, beat_edge[exp_i[exp_i.size()-1]]);
      end
      n_checks++;
      if (pool_done_out !== 1'b1) begin n_fail++; $display("FAIL %s done_hold got %b want 1", name, pool_done_out); end
    end
  endtask

  task automatic test_abort();
    stim.delete();
    for (int k = 0; k < 6; k++) stim.push_back(k);
    drive_inst(4, 32'h200, 1'b0, 1'b1, 1'b0);
    n_checks++; if (pool_done_out !== 1'b0) begin n_fail++; $display("FAIL abort_partial_done got %b want 0", pool_done_out); end
    stim.delete();
    for (int k = 16; k < 32; k++) stim.push_back(k);
    exp_d = '{21, 23, 29, 31}; exp_i = '{5, 7, 13, 15};
    drive_inst(4, 32'h300, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (wr_data.size() != 4) begin n_fail++; $display("FAIL abort_count got %0d want 4", wr_data.size()); end
    for (int k = 0; k < 4 && k < wr_data.size(); k++) begin
      n_checks++;
      if (wr_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL abort_data[%0d] got %0d want %0d", k, wr_data[k], exp_d[k]); end
      n_checks++;
      if (wr_addr[k] !== 32'h300 + k) begin n_fail++; $display("FAIL abort_addr[%0d] got %h want %h", k, wr_addr[k], 32'h300 + k); end
      n_checks++;
      if (wr_cyc[k] != beat_edge[exp_i[k]]) begin n_fail++; $display("FAIL abort_latency[%0d] got %0d want %0d", k, wr_cyc[k], beat_edge[exp_i[k]]); end
    end
    n_checks++; if (pool_done_out !== 1'b1) begin n_fail++; $display("FAIL abort_done got %b want 1", pool_done_out); end
  endtask

  task automatic test_reset_midrun();
    stim = '{1, 2, 3, 4, 5, 6};
    drive_inst(4, 32'h40, 1'b0, 1'b0, 1'b0);
    conv_en_in = 1'b1; conv_data_in = 32'd77; Rst = 1'b1;
    tag = 1'b0; inst_tag_in = 1'b0;
    @(posedge Clk0); #1;
    n_checks++; if (mem_wr_en_out !== 1'b0) begin n_fail++; $display("FAIL midrst_en got %b want 0", mem_wr_en_out); end
    n_checks++; if (mem_wr_addr_out !== 32'h0) begin n_fail++; $display("FAIL midrst_addr got %h want 0", mem_wr_addr_out); end
    n_checks++; if (mem_wr_data_out !== 32'h0) begin n_fail++; $display("FAIL midrst_data got %h want 0", mem_wr_data_out); end
    Rst = 1'b0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    repeat (5) begin
      conv_en_in = 1'b1; conv_data_in = $urandom;
      @(posedge Clk0); #1;
    end
    conv_en_in = 1'b0;
    @(posedge Clk0); #1;
    n_checks++; if (wr_data.size() != 0) begin n_fail++; $display("FAIL midrst_ignored got %0d writes want 0", wr_data.size()); end
    n_checks++; if (pool_done_out !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", pool_done_out); end
    stim = '{9, -4, 8, 3};
    drive_inst(2, 32'h60, 1'b0, 1'b0, 1'b0);
    n_checks++; if (wr_data.size() != 4) begin n_fail++; $display("FAIL recover_count got %0d want 4", wr_data.size()); end
    n_checks++;
    if (wr_addr.size() > 0 && wr_addr[0] !== 32'h60) begin n_fail++; $display("FAIL recover_addr got %h want 60", wr_addr[0]); end
  endtask

  task automatic test_random();
    int n, h, a;
    bit relu, pool;
    logic [31:0] dst;
    logic signed [31:0] vv[$];
    logic signed [31:0] m;
    for (int it = 0; it < 12; it++) begin
      n    = (it == 0) ? 3 : $urandom_range(2, 10);
      pool = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      relu = 1'($urandom_range(0, 1));
      dst  = (it == 0) ? 32'hFFFF_FFFE : $urandom;
      stim.delete(); vv.delete(); exp_d.delete(); exp_i.delete();
      for (int k = 0; k < n * n; k++) begin
        if (it % 2 == 0) stim.push_back($urandom);
        else             stim.push_back($signed($urandom_range(0, 40)) - 20);
      end
      drive_inst(n, dst, relu, pool, 1'b1);
      foreach (stim[k]) vv.push_back((relu && stim[k] < 0) ? 32'sd0 : stim[k]);
      if (pool) begin
        h = n / 2;
        for (int i = 0; i < h; i++) begin
          for (int j = 0; j < h; j++) begin
            a = 2 * i * n + 2 * j;
            m = vv[a];
            if (vv[a+1] > m)   m = vv[a+1];
            if (vv[a+n] > m)   m = vv[a+n];
            if (vv[a+n+1] > m) m = vv[a+n+1];
            exp_d.push_back(m);
            exp_i.push_back(a + n + 1);
          end
        end
      end else begin
        foreach (vv[k]) begin exp_d.push_back(vv[k]); exp_i.push_back(k); end
      end
      n_checks++;
      if (wr_data.size() != exp_d.size()) begin
        n_fail++; $display("FAIL rand%0d count got %0d want %0d (n=%0d pool=%0d)", it, wr_data.size(), exp_d.size(), n, pool);
      end
      for (int k = 0; k < exp_d.size() && k < wr_data.size(); k++) begin
        n_checks++;
        if (wr_data[k] !== exp_d[k]) begin
          n_fail++; $display("FAIL rand%0d data[%0d] got %0d want %0d", it, k, $signed(wr_data[k]), exp_d[k]);
        end
        n_checks++;
        if (wr_addr[k] !== 32'(dst + k)) begin
          n_fail++; $display("FAIL rand%0d addr[%0d] got %h want %h", it, k, wr_addr[k], 32'(dst + k));
        end
        n_checks++;
        if (wr_cyc[k] != beat_edge[exp_i[k]]) begin
          n_fail++; $display("FAIL rand%0d latency[%0d] got %0d want %0d", it, k, wr_cyc[k], beat_edge[exp_i[k]]);
        end
      end
      n_checks++;
      if (done_cyc != beat_edge[exp_i[exp_i.size()-1]]) begin
        n_fail++; $display("FAIL rand%0d done_rise got %0d want %0d", it, done_cyc, beat_edge[exp_i[exp_i.size()-1]]);
      end
      n_checks++;
      if (pool_done_out !== 1'b1) begin n_fail++; $display("FAIL rand%0d done_hold got %b want 1", it, pool_done_out); end
    end
  endtask

  initial begin
    Rst = 1'b1; out_size_in = '0; dst_addr_in = '0; relu_en_in = 1'b0; pool_en_in = 1'b0;
    inst_tag_in = 1'b0; conv_en_in = 1'b0; conv_data_in = '0;
    test_reset();
    test_directed();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
